dna_reader: RTL and testbench

- Controller that drives the Xilinx DNA_PORT primitive and reads the 57-bit device DNA out serially.
- Produces a divided DNA clock, sequences READ and SHIFT, and captures DOUT MSB-first.
- Presents the complete value as a parallel word with a sticky valid flag.
- Sits between DNA_PORT and the system-info register block, which consumes dna_o/valid_o.

---
 rtl/dna_reader.sv | 145 ++++++++++++++
 tb/tb_dna_reader.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/dna_reader.sv
// Serial reader for the DNA_PORT primitive: divides clk_i into a DNA clock, issues READ then
// SHIFT, captures DOUT MSB-first and presents the full identifier with a sticky valid flag.
module dna_reader #(
    parameter int DnaWidth  = 57,
    parameter int ClkDiv    = 2,
    parameter bit AutoStart = 1'b1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    output logic                busy_o,
    output logic                valid_o,
    output logic [DnaWidth-1:0] dna_o,
    output logic                dna_clk_o,
    output logic                dna_read_o,
    output logic                dna_shift_o,
    output logic                dna_din_o,
    input  logic                dna_dout_i
);

    localparam int CntW = $clog2(DnaWidth + 1);
    localparam int DivW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(ClkDiv - 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DnaWidth);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_SHIFT
    } state_t;

    state_t               state_reg, state_next;
    logic [DivW-1:0]      div_reg, div_next;
    logic [CntW-1:0]      cnt_reg, cnt_next;
    logic [DnaWidth-1:0]  cap_reg, cap_next;
    logic [DnaWidth-1:0]  dna_reg, dna_next;
    logic                 dclk_reg, dclk_next;
    logic                 read_reg, read_next;
    logic                 shift_reg, shift_next;
    logic                 busy_reg, busy_next;
    logic                 valid_reg, valid_next;
    logic                 auto_reg, auto_next;
    logic                 tick;
    logic                 fall;
    logic [CntW-1:0]      cnt_inc;

    assign tick    = (div_reg == DivLast);
    assign fall    = tick && dclk_reg;
    assign cnt_inc = cnt_reg + CntW'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= ST_IDLE;
            div_reg   <= '0;
            cnt_reg   <= '0;
            cap_reg   <= '0;
            dna_reg   <= '0;
            dclk_reg  <= 1'b0;
            read_reg  <= 1'b0;
            shift_reg <= 1'b0;
            busy_reg  <= 1'b0;
            valid_reg <= 1'b0;
            // A pending auto-start is consumed in the first cycle after release.
            auto_reg  <= AutoStart;
        end else begin
            state_reg <= state_next;
            div_reg   <= div_next;
            cnt_reg   <= cnt_next;
            cap_reg   <= cap_next;
            dna_reg   <= dna_next;
            dclk_reg  <= dclk_next;
            read_reg  <= read_next;
            shift_reg <= shift_next;
            busy_reg  <= busy_next;
            valid_reg <= valid_next;
            auto_reg  <= auto_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        div_next   = div_reg;
        cnt_next   = cnt_reg;
        cap_next   = cap_reg;
        dna_next   = dna_reg;
        dclk_next  = dclk_reg;
        read_next  = read_reg;
        shift_next = shift_reg;
        busy_next  = busy_reg;
        valid_next = valid_reg;
        auto_next  = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                div_next  = '0;
                dclk_next = 1'b0;
                if (start_i || auto_reg) begin
                    state_next = ST_READ;
                    read_next  = 1'b1;
                    busy_next  = 1'b1;
                    valid_next = 1'b0;
                    cnt_next   = '0;
                end
            end
            ST_READ, ST_SHIFT: begin
                div_next = tick ? '0 : div_reg + DivW'(1);
                if (tick) begin
                    dclk_next = ~dclk_reg;
                end
                // All control changes and DOUT sampling sit on the DNA clock's falling edge,
                // leaving ClkDiv cycles of margin on either side of each rising edge.
                if (fall) begin
                    cap_next = {cap_reg[DnaWidth-2:0], dna_dout_i};
                    if (state_reg == ST_READ) begin
                        cnt_next   = CntW'(1);
                        read_next  = 1'b0;
                        shift_next = 1'b1;
                        state_next = ST_SHIFT;
                    end else begin
                        cnt_next = cnt_inc;
                        if (cnt_inc == CntLast) begin
                            shift_next = 1'b0;
                            dna_next   = {cap_reg[DnaWidth-2:0], dna_dout_i};
                            valid_next = 1'b1;
                            busy_next  = 1'b0;
                            state_next = ST_IDLE;
                        end
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign busy_o      = busy_reg;
    assign valid_o     = valid_reg;
    assign dna_o       = dna_reg;
    assign dna_clk_o   = dclk_reg;
    assign dna_read_o  = read_reg;
    assign dna_shift_o = shift_reg;
    assign dna_din_o   = 1'b0;

endmodule

// File: tb/tb_dna_reader.sv
// Directed bench for dna_reader: three instances (auto-start ClkDiv=2, manual ClkDiv=2,
// manual ClkDiv=1), each connected to a behavioural DNA_PORT model.
module tb_dna_reader;

    localparam logic [56:0] V1 = 57'h1B8A94D76732894;
    localparam logic [56:0] V2 = 57'h0AAAAAAAAAAAAAA;

    logic        clk = 1'b0;
    logic [2:0]  rst_n = 3'b000;
    logic [2:0]  start = 3'b000;
    logic [2:0]  busy, valid, dclk, dread, dshift, ddin, ddout;
    logic [56:0] dna  [3];
    logic [56:0] mval [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        logic [56:0] sr;
        always @(posedge dclk[gi]) begin
            if (dread[gi]) sr <= mval[gi];
            else if (dshift[gi]) sr <= {sr[55:0], ddin[gi]};
        end
        assign ddout[gi] = sr[56];

        dna_reader #(
            .DnaWidth (57),
            .ClkDiv   ((gi == 2) ? 1 : 2),
            .AutoStart((gi == 0) ? 1'b1 : 1'b0)
        ) u_dut (
            .clk_i      (clk),
            .rst_ni     (rst_n[gi]),
            .start_i    (start[gi]),
            .busy_o     (busy[gi]),
            .valid_o    (valid[gi]),
            .dna_o      (dna[gi]),
            .dna_clk_o  (dclk[gi]),
            .dna_read_o (dread[gi]),
            .dna_shift_o(dshift[gi]),
            .dna_din_o  (ddin[gi]),
            .dna_dout_i (ddout[gi])
        );
    end

    // DNA clock monitor for instance 0, sampled on the falling clk edge.
    int   rises = 0, read_rises = 0, hp_bad = 0, ctl_bad = 0, din_bad = 0;
    int   hi_run = 0, lo_run = 0;
    logic prev_dclk = 1'b0;
    always @(negedge clk) begin
        prev_dclk <= dclk[0];
        hi_run    <= dclk[0] ? hi_run + 1 : 0;
        lo_run    <= dclk[0] ? 0 : lo_run + 1;
        if (!dclk[0] && prev_dclk) begin
            if (hi_run != 2) hp_bad <= hp_bad + 1;
        end else if (dclk[0] && !prev_dclk) begin
            rises <= rises + 1;
            if (dread[0]) read_rises <= read_rises + 1;
            if (!(dread[0] ^ dshift[0])) ctl_bad <= ctl_bad + 1;
            if (dshift[0] && lo_run != 2) hp_bad <= hp_bad + 1;
        end
        if (ddin[0]) din_bad <= din_bad + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s got=%h", tag, got);
        end
    endtask

    task automatic wait_valid(input int idx, output int n);
        n = 0;
        while (n < 1000) begin
            @(posedge clk);
            #1;
            n++;
            if (valid[idx]) break;
        end
    endtask

    task automatic pulse_start(input int idx);
        @(negedge clk);
        start[idx] = 1'b1;
        @(posedge clk);
        #1;
        start[idx] = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    int lat;
    int r0, rr0;

    initial begin
        mval[0] = V1;
        mval[1] = V2;
        mval[2] = V1;
        wait_cycles(3);
        chk("rst_busy",  64'(busy[0]),   64'd0);
        chk("rst_valid", 64'(valid[0]),  64'd0);
        chk("rst_dna",   64'(dna[0]),    64'd0);
        chk("rst_ctl",   64'({dclk[0], dread[0], dshift[0], ddin[0]}), 64'd0);

        // 1+2: auto-start acquisition with edge accounting
        r0 = rises; rr0 = read_rises;
        @(negedge clk);
        rst_n = 3'b111;
        @(posedge clk);
        #1;
        chk("auto_busy", 64'(busy[0]),  64'd1);
        chk("auto_read", 64'(dread[0]), 64'd1);
        wait_valid(0, lat);
        chk("auto_lat",  64'(lat),     64'd228);
        chk("auto_dna",  64'(dna[0]),  64'(V1));
        chk("auto_idle", 64'(busy[0]), 64'd0);
        wait_cycles(4);
        chk("rises",      64'(rises - r0),       64'd57);
        chk("read_rises", 64'(read_rises - rr0), 64'd1);
        chk("ctl_bad",    64'(ctl_bad),          64'd0);
        chk("half_per",   64'(hp_bad),           64'd0);
        chk("din_zero",   64'(din_bad),          64'd0);

        // 3: manual start, ClkDiv=2 then ClkDiv=1; nothing happens before the pulse
        chk("man_idle", 64'({busy[2:1], dclk[2:1], dread[2:1], valid[2:1]}), 64'd0);
        pulse_start(1);
        chk("man2_busy", 64'(busy[1]), 64'd1);
        wait_valid(1, lat);
        chk("man2_lat", 64'(lat),    64'd228);
        chk("man2_dna", 64'(dna[1]), 64'(V2));
        pulse_start(2);
        wait_valid(2, lat);
        chk("man1_lat", 64'(lat),    64'd114);
        chk("man1_dna", 64'(dna[2]), 64'(V1));

        // 4: start held 50 cycles gives a single acquisition
        r0 = rises;
        @(negedge clk);
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("hold_valid0", 64'(valid[0]), 64'd0);
        for (int i = 0; i < 49; i++) begin
            @(posedge clk);
            #1;
        end
        start[0] = 1'b0;
        lat = 0;
        while (lat < 1000) begin
            @(posedge clk);
            #1;
            lat++;
            if (valid[0]) break;
        end
        chk("hold_lat",   64'(lat + 49), 64'd228);
        wait_cycles(4);
        chk("hold_rises", 64'(rises - r0), 64'd57);
        chk("hold_idle",  64'(busy[0]),    64'd0);

        // 5: re-acquisition with a new value; old value held until completion
        mval[0] = V2;
        pulse_start(0);
        chk("re_valid0", 64'(valid[0]), 64'd0);
        chk("re_hold0",  64'(dna[0]),   64'(V1));
        wait_cycles(100);
        chk("re_hold1",  64'(dna[0]),   64'(V1));
        lat = 100;
        while (lat < 1000) begin
            @(posedge clk);
            #1;
            lat++;
            if (valid[0]) break;
        end
        chk("re_lat", 64'(lat),    64'd228);
        chk("re_dna", 64'(dna[0]), 64'(V2));

        // 6: asynchronous reset mid-shift, then clean auto-start acquisition
        mval[0] = V1;
        pulse_start(0);
        wait_cycles(100);
        #2;
        rst_n[0] = 1'b0;
        #1;
        chk("ar_busy",  64'(busy[0]),  64'd0);
        chk("ar_valid", 64'(valid[0]), 64'd0);
        chk("ar_dna",   64'(dna[0]),   64'd0);
        chk("ar_ctl",   64'({dclk[0], dread[0], dshift[0]}), 64'd0);
        wait_cycles(3);
        @(negedge clk);
        rst_n[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("ar_restart", 64'(busy[0]), 64'd1);
        wait_valid(0, lat);
        chk("ar_lat", 64'(lat),    64'd228);
        chk("ar_dna2", 64'(dna[0]), 64'(V1));
        wait_cycles(4);
        chk("end_ctl", 64'(ctl_bad + hp_bad + din_bad), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
